// File: rtl/capture_wr_ctrl.sv
// ADC capture buffer write-side controller.
// Single-shot fill or triggered ring capture with post-trigger length.
module capture_wr_ctrl #(
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              rf_capture_start,
  input  logic              rf_capture_abort,
  input  logic              rf_mode,
  input  logic [ADDR_W-1:0] rf_last_addr,
  input  logic [ADDR_W-1:0] rf_post_len,
  input  logic              trig_in,
  input  logic              write_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] waddr,
  output logic              wr_done,
  output logic              busy,
  output logic [ADDR_W-1:0] trig_addr,
  output logic              wrapped
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_POST,
    S_DONE
  } state_e;

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
  logic [ADDR_W-1:0] post_cnt_q, post_cnt_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [ADDR_W-1:0] post_len_q, post_len_d;
  logic              mode_q, mode_d;
  logic              wr_done_q, wr_done_d;
  logic              wrapped_q, wrapped_d;

  logic              busy_w;
  logic              accept;
  logic              at_last;
  logic [ADDR_W-1:0] ptr_nxt;

  assign busy_w  = (state_q == S_FILL) || (state_q == S_POST);
  assign accept  = write_en && busy_w;
  assign at_last = (waddr_q == last_q);
  assign ptr_nxt = at_last ? '0 : waddr_q + ONE;

  assign mem_we    = accept;
  assign busy      = busy_w;
  assign waddr     = waddr_q;
  assign wr_done   = wr_done_q;
  assign trig_addr = trig_addr_q;
  assign wrapped   = wrapped_q;

  // Next-state: abort beats start beats normal capture progress.
  always_comb begin
    state_d     = state_q;
    waddr_d     = waddr_q;
    trig_addr_d = trig_addr_q;
    post_cnt_d  = post_cnt_q;
    last_d      = last_q;
    post_len_d  = post_len_q;
    mode_d      = mode_q;
    wr_done_d   = wr_done_q;
    wrapped_d   = wrapped_q;
    if (rf_capture_abort) begin
      state_d     = S_IDLE;
      waddr_d     = '0;
      wrapped_d   = 1'b0;
      trig_addr_d = '0;
      wr_done_d   = 1'b0;
    end else if (rf_capture_start) begin
      state_d     = S_FILL;
      waddr_d     = '0;
      wrapped_d   = 1'b0;
      trig_addr_d = '0;
      wr_done_d   = 1'b0;
      mode_d      = rf_mode;
      last_d      = rf_last_addr;
      post_len_d  = rf_post_len;
    end else begin
      case (state_q)
        S_FILL: begin
          if (accept) begin
            waddr_d = ptr_nxt;
            if (at_last) wrapped_d = 1'b1;
          end
          if (!mode_q) begin
            if (accept && at_last) begin
              state_d   = S_DONE;
              wr_done_d = 1'b1;
            end
          end else if (trig_in) begin
            trig_addr_d = waddr_q;
            post_cnt_d  = post_len_q;
            if (post_len_q != '0) begin
              state_d = S_POST;
            end else begin
              state_d   = S_DONE;
              wr_done_d = 1'b1;
            end
          end
        end
        S_POST: begin
          if (accept) begin
            waddr_d    = ptr_nxt;
            post_cnt_d = post_cnt_q - ONE;
            if (at_last) wrapped_d = 1'b1;
            if (post_cnt_q == ONE) begin
              state_d   = S_DONE;
              wr_done_d = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // State and shadow config registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      waddr_q     <= '0;
      trig_addr_q <= '0;
      post_cnt_q  <= '0;
      last_q      <= '0;
      post_len_q  <= '0;
      mode_q      <= 1'b0;
      wr_done_q   <= 1'b0;
      wrapped_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      waddr_q     <= waddr_d;
      trig_addr_q <= trig_addr_d;
      post_cnt_q  <= post_cnt_d;
      last_q      <= last_d;
      post_len_q  <= post_len_d;
      mode_q      <= mode_d;
      wr_done_q   <= wr_done_d;
      wrapped_q   <= wrapped_d;
    end
  end

endmodule

// File: tb/tb_capture_wr_ctrl.sv
// Bench for capture_wr_ctrl: capture model plus directed scenarios.
// Per-cycle compare against the model, literal checks pin key points.
module tb_capture_wr_ctrl;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          mode = 1'b0;
  logic [AW-1:0] last = '0;
  logic [AW-1:0] plen = '0;
  logic          trig = 1'b0;
  logic          we = 1'b0;

  logic          mem_we;
  logic [AW-1:0] waddr;
  logic          wr_done;
  logic          busy;
  logic [AW-1:0] trig_addr;
  logic          wrapped;

  int n_cmp = 0;
  int n_bad = 0;

  logic [AW-1:0] wlog[$];

  capture_wr_ctrl #(.ADDR_W(AW)) dut (
    .clk              (clk),
    .rstn             (rstn),
    .rf_capture_start (start),
    .rf_capture_abort (abort),
    .rf_mode          (mode),
    .rf_last_addr     (last),
    .rf_post_len      (plen),
    .trig_in          (trig),
    .write_en         (we),
    .mem_we           (mem_we),
    .waddr            (waddr),
    .wr_done          (wr_done),
    .busy             (busy),
    .trig_addr        (trig_addr),
    .wrapped          (wrapped)
  );

  always #5 clk = ~clk;

  // Model: phase 0 idle, 1 capturing before trigger, 2 after trigger, 3 done.
  int            m_ph = 0;
  int            m_ptr = 0;
  int            m_taddr = 0;
  int            m_rem = 0;
  int            m_last = 0;
  int            m_plen = 0;
  bit            m_mode = 0;
  bit            m_done = 0;
  bit            m_wrap = 0;

  always @(posedge clk or negedge rstn) begin
    int ph, ptr, ta, rem;
    bit dn, wr;
    if (!rstn) begin
      m_ph <= 0; m_ptr <= 0; m_taddr <= 0; m_rem <= 0;
      m_last <= 0; m_plen <= 0; m_mode <= 0; m_done <= 0; m_wrap <= 0;
    end else if (abort) begin
      m_ph <= 0; m_ptr <= 0; m_taddr <= 0; m_done <= 0; m_wrap <= 0;
    end else if (start) begin
      m_ph <= 1; m_ptr <= 0; m_taddr <= 0; m_done <= 0; m_wrap <= 0;
      m_mode <= mode; m_last <= int'(last); m_plen <= int'(plen);
    end else if (m_ph == 1 || m_ph == 2) begin
      ph = m_ph; ptr = m_ptr; ta = m_taddr; rem = m_rem;
      dn = m_done; wr = m_wrap;
      if (we) begin
        if (m_ptr == m_last) begin
          ptr = 0;
          wr = 1;
        end else begin
          ptr = (m_ptr + 1) % (1 << AW);
        end
      end
      if (m_ph == 1 && !m_mode && we && m_ptr == m_last) begin
        ph = 3; dn = 1;
      end
      if (m_ph == 1 && m_mode && trig) begin
        ta = m_ptr;
        rem = m_plen;
        if (m_plen == 0) begin ph = 3; dn = 1; end
        else ph = 2;
      end
      if (m_ph == 2 && we) begin
        rem = m_rem - 1;
        if (rem == 0) begin ph = 3; dn = 1; end
      end
      m_ph <= ph; m_ptr <= ptr; m_taddr <= ta; m_rem <= rem;
      m_done <= dn; m_wrap <= wr;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, also logs written addresses.
  always @(negedge clk) begin
    bit cap;
    cap = (m_ph == 1 || m_ph == 2);
    chk("mem_we", int'(mem_we), int'(we && cap));
    chk("busy", int'(busy), int'(cap));
    chk("waddr", int'(waddr), m_ptr);
    chk("wr_done", int'(wr_done), int'(m_done));
    chk("trig_addr", int'(trig_addr), m_taddr);
    chk("wrapped", int'(wrapped), int'(m_wrap));
    if (mem_we) wlog.push_back(waddr);
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic go(input bit md, input int la, input int pl, input bit w);
    mode = md;
    last = AW'(la);
    plen = AW'(pl);
    we = w;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int seq7[4];
    seq7[0] = 6; seq7[1] = 7; seq7[2] = 0; seq7[3] = 1;

    tick(2);
    chk("rst_waddr", int'(waddr), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(wr_done), 0);
    rstn = 1'b1;
    tick(2);

    // Single-shot fill, last=5, continuous writes.
    wlog.delete();
    go(1'b0, 5, 0, 1'b1);
    tick(6);
    chk("t1_done", int'(wr_done), 1);
    chk("t1_waddr", int'(waddr), 0);
    chk("t1_busy", int'(busy), 0);
    tick(3);
    chk("t1_nwr", wlog.size(), 6);
    for (int i = 0; i < 6 && i < wlog.size(); i++)
      chk("t1_addr", int'(wlog[i]), i);

    // Ring capture, trigger at addr 6 after a wrap, post_len=3.
    wlog.delete();
    go(1'b1, 7, 3, 1'b1);
    tick(14);
    trig = 1'b1;
    tick();
    trig = 1'b0;
    tick(3);
    chk("t2_trig_addr", int'(trig_addr), 6);
    chk("t2_waddr", int'(waddr), 2);
    chk("t2_done", int'(wr_done), 1);
    chk("t2_wrapped", int'(wrapped), 1);
    tick(2);
    chk("t2_nwr", wlog.size(), 18);
    for (int i = 0; i < 4 && wlog.size() == 18; i++)
      chk("t2_tail", int'(wlog[14 + i]), seq7[i]);

    // Ring capture, post_len=0, trigger with no write at addr 3.
    wlog.delete();
    go(1'b1, 7, 0, 1'b1);
    tick(3);
    we = 1'b0;
    trig = 1'b1;
    tick();
    trig = 1'b0;
    chk("t3_trig_addr", int'(trig_addr), 3);
    chk("t3_waddr", int'(waddr), 3);
    chk("t3_done", int'(wr_done), 1);
    we = 1'b1;
    tick(3);
    chk("t3_nwr", wlog.size(), 3);
    chk("t3_waddr2", int'(waddr), 3);

    // Gapped single-shot fill, last=9; config change mid-capture ignored.
    wlog.delete();
    go(1'b0, 9, 0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      we = (i % 3 == 0);
      if (i == 6) last = AW'(2);
      tick();
    end
    we = 1'b0;
    chk("t4_nwr", wlog.size(), 10);
    for (int i = 0; i < 10 && i < wlog.size(); i++)
      chk("t4_addr", int'(wlog[i]), i);
    chk("t4_done", int'(wr_done), 1);

    // Restart mid-post, then abort during fill.
    go(1'b1, 7, 5, 1'b1);
    tick(10);
    trig = 1'b1;
    tick();
    trig = 1'b0;
    tick();
    chk("t5_pre_wrap", int'(wrapped), 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t5_waddr", int'(waddr), 0);
    chk("t5_wrapped", int'(wrapped), 0);
    chk("t5_done", int'(wr_done), 0);
    chk("t5_busy", int'(busy), 1);
    chk("t5_taddr", int'(trig_addr), 0);
    tick(2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5_ab_busy", int'(busy), 0);
    chk("t5_ab_we", int'(mem_we), 0);
    chk("t5_ab_waddr", int'(waddr), 0);
    tick(2);

    // Asynchronous reset mid-fill at addr 4.
    go(1'b0, 9, 0, 1'b1);
    tick(4);
    chk("t6_pre_waddr", int'(waddr), 4);
    rstn = 1'b0;
    #1;
    chk("t6_waddr", int'(waddr), 0);
    chk("t6_busy", int'(busy), 0);
    chk("t6_we", int'(mem_we), 0);
    #2;
    rstn = 1'b1;
    wlog.delete();
    tick(4);
    chk("t6_nwr", wlog.size(), 0);
    chk("t6_idle", int'(busy), 0);
    we = 1'b0;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
